shift_sched: RTL and testbench
==============================

SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter n, default 8: data width; matches the slr stage's n.
REQ-002 Parameter amt_n, default 3: per-beat shift-amount width; matches the slr stage's amt_n.
REQ-003 Parameter tot_n, default 5: total requested shift-amount width; must satisfy tot_n >= amt_n.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: request present.
REQ-007 Port in_ready, output, 1: scheduler can accept a request.
REQ-008 Port in_d, input, n: data to shift right logically.
REQ-009 Port in_amt, input, tot_n: total shift amount, 0..2^tot_n-1.
REQ-010 Port o_valid, output, 1: beat valid toward the downstream slr stage (drives its en).
REQ-011 Port o_ready, input, 1: downstream accepts the beat.
REQ-012 Port o_d, output, n: beat data (drives slr d).
REQ-013 Port o_amt, output, amt_n: beat shift amount (drives slr amt).
REQ-014 Port o_last, output, 1: final beat of the current request.
REQ-015 Port busy, output, 1: request in progress.

Function
REQ-016 Purpose: split one request into beats, each shifting by at most MAX = 2^amt_n-1, so the downstream slr stage applied to the final beat yields in_d >> in_amt with zero fill.
REQ-017 State machine: IDLE, ISSUE. Registers: cur (n bits), rem (tot_n bits).
REQ-018 IDLE behaviour: in_ready=1, o_valid=0, busy=0.
REQ-019 Request acceptance: in IDLE, in_valid=1 loads cur<=in_d and rem<=in_amt, and moves to ISSUE on that edge.
REQ-020 ISSUE outputs (all combinational from registers): in_ready=0, busy=1, o_valid=1, o_d=cur, o_amt=min(rem,MAX), o_last=(rem<=MAX).
REQ-021 Beat transfer: a beat transfers only on an edge where o_valid=1 and o_ready=1; on transfer cur<=cur>>o_amt and rem<=rem-o_amt.
REQ-022 Return to IDLE: a transfer with o_last=1 moves to IDLE; in_ready is 1 on the next cycle, giving one idle bubble between requests.
REQ-023 Backpressure: while o_ready=0, o_d, o_amt and o_last hold stable and o_valid stays 1; the scheduler never withdraws a beat.
REQ-024 Zero shift: in_amt=0 produces exactly one beat with o_amt=0, o_last=1, o_d=in_d.
REQ-025 Exact multiple: in_amt=k*MAX produces exactly k beats, each with o_amt=MAX; no trailing zero-amount beat is issued.
REQ-026 Beat count: a request issues ceil(in_amt/MAX) beats, or 1 beat if in_amt=0.
REQ-027 Large shifts: in_amt>=n is still fully sequenced; the downstream result is 0; no early termination.
REQ-028 Input gating: in_valid is ignored outside IDLE; no queuing or overwrite of the in-flight request.
REQ-029 Arithmetic: all shifts are logical with zero fill; rem never underflows.

Reset
REQ-030 While rst=0, asynchronously force: state=IDLE, cur=0, rem=0, o_valid=0, o_last=0, o_d=0, o_amt=0, busy=0, in_ready=1.
REQ-031 Reset mid-request discards the request with no further beats; after rst deasserts, the first accepted request starts clean.

Verification
REQ-032 Zero shift: in_d=8'hB4, in_amt=0, o_ready=1 -> one beat (o_d=B4, o_amt=0, o_last=1), then IDLE.
REQ-033 Two-beat request: in_d=8'hB4, in_amt=10 -> beats (B4, 7, last=0) then (01, 3, last=1); the slr result is 8'h00, matching B4>>10.
REQ-034 Exact multiple and maximum: in_amt=7 -> single beat (B4, 7, last=1); in_amt=31 -> five beats with amt 7,7,7,7,3 and last only on the fifth.
REQ-035 Backpressure: in_amt=10 with o_ready=0 for 3 cycles on the first beat -> o_d=B4, o_amt=7 held for 3 cycles; the second beat (01, 3) follows one cycle after o_ready rises.
REQ-036 Ignored request: in_valid held 1 during ISSUE -> ignored; the next request is accepted only after the bubble cycle and in_ready=1.
REQ-037 Reset mid-request: rst=0 during the first beat of in_amt=31 -> o_valid=0 and busy=0 immediately (no clock edge needed); no beats are issued after rst rises until a new request arrives.

Source files
------------

// File: rtl/shift_sched_if.sv
// shift_sched_if: request side and beat side handshake bundle for shift_sched.
// The slave modport is the scheduler; the master modport is whoever drives
// requests and consumes beats (the slr stage plus its upstream).
interface shift_sched_if #(
  parameter int n     = 8,
  parameter int amt_n = 3,
  parameter int tot_n = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [n-1:0]     in_d;
  logic [tot_n-1:0] in_amt;
  logic             o_valid;
  logic             o_ready;
  logic [n-1:0]     o_d;
  logic [amt_n-1:0] o_amt;
  logic             o_last;
  logic             busy;

  modport slave (
    input  in_valid, in_d, in_amt, o_ready,
    output in_ready, o_valid, o_d, o_amt, o_last, busy
  );

  modport master (
    output in_valid, in_d, in_amt, o_ready,
    input  in_ready, o_valid, o_d, o_amt, o_last, busy
  );
endinterface

// File: rtl/shift_sched.sv
// shift_sched: breaks one logical right shift of up to 2^tot_n-1 bits into
// beats of at most 2^amt_n-1 bits each, for a downstream slr stage. The data
// word is pre-shifted locally after every beat, so the slr stage applied to
// the last beat produces in_d >> in_amt with zero fill.
module shift_sched #(
  parameter int n     = 8,
  parameter int amt_n = 3,
  parameter int tot_n = 5
) (
  input logic            clk,
  input logic            rst,
  shift_sched_if.slave   s
);
  // Largest per-beat shift, in both widths it gets compared/assigned at.
  localparam int               max_i = (1 << amt_n) - 1;
  localparam logic [tot_n-1:0] max_t = tot_n'(max_i);
  localparam logic [amt_n-1:0] max_a = '1;

  typedef enum logic {IDLE, ISSUE} st_t;

  st_t              st;
  logic [n-1:0]     cur;   // data as it stands before the current beat
  logic [tot_n-1:0] rem;   // shift still owed, including the current beat

  logic             issue;
  logic             fits;
  logic [amt_n-1:0] beat_amt;

  // Current beat size: whatever is left, capped at the per-beat maximum.
  // Using <= means an exact multiple ends on a full beat, never a 0-beat.
  always_comb begin
    issue    = (st == ISSUE);
    fits     = (rem <= max_t);
    beat_amt = fits ? rem[amt_n-1:0] : max_a;
  end

  // Beat outputs come straight off the registers and are zero outside ISSUE,
  // so they stay stable under backpressure and clear with the reset.
  assign s.in_ready = ~issue;
  assign s.busy     = issue;
  assign s.o_valid  = issue;
  assign s.o_d      = issue ? cur : '0;
  assign s.o_amt    = issue ? beat_amt : '0;
  assign s.o_last   = issue & fits;

  // Sequencer: load in IDLE, step cur/rem on every accepted beat, and return
  // to IDLE on the last one (the next cycle is the idle bubble).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= IDLE;
      cur <= '0;
      rem <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (s.in_valid) begin
            cur <= s.in_d;
            rem <= s.in_amt;
            st  <= ISSUE;
          end
        end
        ISSUE: begin
          if (s.o_ready) begin
            cur <= cur >> beat_amt;
            rem <= rem - tot_n'(beat_amt);
            if (fits) st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: directed bench for shift_sched with a beat-queue model.
// The model expands each accepted request into its full list of beats and
// pops one per handshake; a compare process checks the DUT against the
// queue head every cycle. Directed tests add literal beat lists on top.
module tb_shift_sched;
  typedef struct packed {
    logic [7:0] d;
    logic [2:0] a;
    logic       l;
  } beat_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  shift_sched_if #(.n(8), .amt_n(3), .tot_n(5)) bus ();

  shift_sched #(.n(8), .amt_n(3), .tot_n(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t      mq[$];     // model: beats still owed for the active request
  beat_t      log_q[$];  // beats actually transferred by the DUT
  logic [7:0] exp_res;   // in_d >> in_amt for the last accepted request
  logic [7:0] slr_res;   // what a slr stage would output after the last beat

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: expand a request into beats of min(remaining, 7); pop on handshake.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else if (mq.size() == 0) begin
      if (bus.in_valid) begin
        int         r;
        logic [7:0] c;
        int         a;
        r = int'(bus.in_amt);
        c = bus.in_d;
        exp_res = (r >= 8) ? 8'h00 : (bus.in_d >> r);
        do begin
          a = (r < 7) ? r : 7;
          mq.push_back('{d: c, a: 3'(a), l: (r <= 7)});
          c = c >> a;
          r = r - a;
        end while (r > 0);
      end
    end else if (bus.o_ready) begin
      void'(mq.pop_front());
    end
  end

  // Record every transferred beat and what the slr stage would produce.
  always @(posedge clk) begin
    if (rst && bus.o_valid && bus.o_ready) begin
      log_q.push_back('{d: bus.o_d, a: bus.o_amt, l: bus.o_last});
      if (bus.o_last) slr_res = bus.o_d >> bus.o_amt;
    end
  end

  // Every cycle out of reset: DUT handshake and beat fields against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("o_valid", bus.o_valid, mq.size() != 0);
      chk("in_ready", bus.in_ready, mq.size() == 0);
      chk("busy", bus.busy, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("o_d", bus.o_d, mq[0].d);
        chk("o_amt", bus.o_amt, mq[0].a);
        chk("o_last", bus.o_last, mq[0].l);
      end
    end
  end

  task automatic start(input logic [7:0] d, input logic [4:0] a);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_d     = d;
    bus.in_amt   = a;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic run(input logic [7:0] d, input logic [4:0] a);
    log_q.delete();
    start(d, a);
    wait_idle();
    chk("slr_result", slr_res, exp_res);
  endtask

  task automatic beat(input int i, input logic [7:0] d, input logic [2:0] a, input logic l);
    chk($sformatf("beat%0d_present", i), log_q.size() > i, 1'b1);
    if (log_q.size() > i) begin
      chk($sformatf("beat%0d_d", i), log_q[i].d, d);
      chk($sformatf("beat%0d_amt", i), log_q[i].a, a);
      chk($sformatf("beat%0d_last", i), log_q[i].l, l);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int amts[9] = '{1, 6, 8, 13, 14, 15, 21, 28, 30};
  logic [7:0] dats[9] = '{8'hFF, 8'h81, 8'hC3, 8'h7E, 8'hFF, 8'h5A, 8'hA5, 8'h80, 8'hF0};

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_d     = '0;
    bus.in_amt   = '0;
    bus.o_ready  = 1'b1;
    #12;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_o_valid", bus.o_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_o_d", bus.o_d, 8'h00);
    chk("rst_o_amt", bus.o_amt, 3'd0);
    chk("rst_o_last", bus.o_last, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Zero shift: single passthrough beat.
    run(8'hB4, 5'd0);
    chk("zero_nbeats", log_q.size(), 1);
    beat(0, 8'hB4, 3'd0, 1'b1);

    // Two beats.
    run(8'hB4, 5'd10);
    chk("two_nbeats", log_q.size(), 2);
    beat(0, 8'hB4, 3'd7, 1'b0);
    beat(1, 8'h01, 3'd3, 1'b1);
    chk("two_slr", slr_res, 8'h00);

    // Exact single maximum.
    run(8'hB4, 5'd7);
    chk("max1_nbeats", log_q.size(), 1);
    beat(0, 8'hB4, 3'd7, 1'b1);
    chk("max1_slr", slr_res, 8'h01);

    // Largest request: 7,7,7,7,3.
    run(8'hB4, 5'd31);
    chk("max_nbeats", log_q.size(), 5);
    beat(0, 8'hB4, 3'd7, 1'b0);
    beat(1, 8'h01, 3'd7, 1'b0);
    beat(2, 8'h00, 3'd7, 1'b0);
    beat(3, 8'h00, 3'd7, 1'b0);
    beat(4, 8'h00, 3'd3, 1'b1);

    // Exact multiple of the max: 14 -> two full beats, no trailing 0-beat.
    run(8'hFF, 5'd14);
    chk("mult_nbeats", log_q.size(), 2);
    beat(1, 8'h01, 3'd7, 1'b1);

    // Backpressure on the first beat for 3 cycles.
    log_q.delete();
    bus.o_ready = 1'b0;
    start(8'hB4, 5'd10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", bus.o_valid, 1'b1);
      chk("bp_d", bus.o_d, 8'hB4);
      chk("bp_amt", bus.o_amt, 3'd7);
      chk("bp_last", bus.o_last, 1'b0);
    end
    @(posedge clk); #1;
    bus.o_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_next_d", bus.o_d, 8'h01);
    chk("bp_next_amt", bus.o_amt, 3'd3);
    chk("bp_next_last", bus.o_last, 1'b1);
    wait_idle();
    chk("bp_nbeats", log_q.size(), 2);

    // in_valid held through ISSUE: ignored until after the bubble.
    log_q.delete();
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_d     = 8'hB4;
    bus.in_amt   = 5'd10;
    @(posedge clk); #1;
    bus.in_d     = 8'hFF;
    bus.in_amt   = 5'd1;
    wait_idle();
    chk("ign_bubble_ready", bus.in_ready, 1'b1);
    chk("ign_first_nbeats", log_q.size(), 2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("ign_accepted", bus.busy, 1'b1);
    wait_idle();
    chk("ign_nbeats", log_q.size(), 3);
    beat(0, 8'hB4, 3'd7, 1'b0);
    beat(1, 8'h01, 3'd3, 1'b1);
    beat(2, 8'hFF, 3'd1, 1'b1);
    chk("ign_slr", slr_res, 8'h7F);

    // Reset during the first beat of a 31-bit request.
    log_q.delete();
    start(8'hB4, 5'd31);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_o_valid", bus.o_valid, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    chk("mid_rst_o_d", bus.o_d, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    log_q.delete();
    repeat (5) @(negedge clk);
    chk("post_rst_nbeats", log_q.size(), 0);
    chk("post_rst_o_valid", bus.o_valid, 1'b0);
    run(8'hB4, 5'd3);
    chk("post_rst_req_nbeats", log_q.size(), 1);
    beat(0, 8'hB4, 3'd3, 1'b1);
    chk("post_rst_slr", slr_res, 8'h16);

    // Sweep of amounts around and between multiples of 7.
    for (int i = 0; i < 9; i++) begin
      run(dats[i], 5'(amts[i]));
      chk($sformatf("sweep%0d_nbeats", i), log_q.size(), (amts[i] + 6) / 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
